// File: rtl/mem_responder.sv
// mem_responder: queues read requests and answers each with len+1 incrementing-address beats, LATENCY cycles after dequeue.
// Optional MEM_RESP_STALL_EN adds slv_resp_ready so the consumer can stall response beats.
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

package mem_responder_pkg;
    typedef struct packed {
        logic [`REQ_ID_WIDTH-1:0] id;
        logic [`ADDR_WIDTH-1:0]   addr;
        logic [3:0]               len;
    } mem_req_t;

    typedef struct packed {
        logic [`REQ_ID_WIDTH-1:0] id;
        logic [`DATA_WIDTH-1:0]   data;
        logic                     last;
    } mem_resp_t;
endpackage

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LATENCY    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  mem_req_t   slv_req,
    input  logic       slv_req_valid,
    output logic       slv_req_ready,
    output mem_resp_t  slv_resp,
    output logic       slv_resp_valid,
`ifdef MEM_RESP_STALL_EN
    input  logic       slv_resp_ready,
`endif
    output logic [4:0] outstanding
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    mem_req_t          fifo_mem [FIFO_DEPTH];
    logic [CW-1:0]     wr_ptr, rd_ptr, fifo_cnt;
    logic              fifo_empty, accept, pop;
    mem_req_t          head;

    state_t            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [3:0]        beat_q, beat_d;
    logic [`REQ_ID_WIDTH-1:0] svc_id;
    logic [`ADDR_WIDTH-1:0]   svc_addr;
    logic [3:0]        svc_len;
    logic [`ADDR_WIDTH-1:0]   beat_addr;
    logic              beat_last, resp_take, last_xfer;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign fifo_cnt      = wr_ptr - rd_ptr;
    assign fifo_empty    = (fifo_cnt == '0);
    assign slv_req_ready = (fifo_cnt < DEPTH_C);
    assign accept        = slv_req_valid & slv_req_ready;
    assign head          = fifo_mem[rd_ptr[AW-1:0]];

`ifdef MEM_RESP_STALL_EN
    assign resp_take = slv_resp_ready;
`else
    assign resp_take = 1'b1;
`endif

    assign beat_last = (beat_q == svc_len);
    assign last_xfer = slv_resp_valid & resp_take & beat_last;
    assign beat_addr = svc_addr + `ADDR_WIDTH'(beat_q);

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr[AW-1:0]] <= slv_req;
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        beat_d         = beat_q;
        pop            = 1'b0;
        slv_resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    wait_d  = 4'(LATENCY);
                    beat_d  = 4'd0;
                    state_d = (LATENCY == 0) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (wait_q <= 4'd1) begin
                    wait_d  = 4'd0;
                    state_d = BURST;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            BURST: begin
                slv_resp_valid = 1'b1;
                if (resp_take) begin
                    if (beat_last) begin
                        beat_d  = 4'd0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slv_resp = '0;
        if (slv_resp_valid) begin
            slv_resp.id   = svc_id;
            slv_resp.data = `DATA_WIDTH'(beat_addr);
            slv_resp.last = beat_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            state_q     <= IDLE;
            wait_q      <= 4'd0;
            beat_q      <= 4'd0;
            svc_id      <= '0;
            svc_addr    <= '0;
            svc_len     <= 4'd0;
            outstanding <= 5'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            if (accept) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + CW'(1);
                svc_id   <= head.id;
                svc_addr <= head.addr;
                svc_len  <= head.len;
            end
            // A coinciding accept and completion cancel out.
            case ({accept, last_xfer})
                2'b10:   outstanding <= outstanding + 5'd1;
                2'b01:   outstanding <= outstanding - 5'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end
endmodule
